hazard_ctrl: RTL

//  Pipeline stall/flush sequencer for the 5-stage core. Works alongside the forwarding unit and covers what

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus: hazard inputs from the ID/EX/MEM stages and the stall/flush controls back.
// The controller side uses modport master; the pipeline side uses modport slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rt_i;
  logic [4:0]       IFID_Rs_i;
  logic [4:0]       IFID_Rt_i;
  logic             Branch_i;
  // MemReq_i/MemAck_i: the access completes on any cycle where both are high; req without ack is a wait.
  logic             MemReq_i;
  logic             MemAck_i;
  logic             PC_Write_o;
  logic             IFID_Write_o;
  logic             IFID_Flush_o;
  logic             IDEX_Write_o;
  logic             IDEX_Bubble_o;
  logic             EXMEM_Write_o;
  logic             MEMWB_Bubble_o;
  logic             MemTimeout_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i, MemReq_i, MemAck_i,
    output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o, IDEX_Bubble_o,
           EXMEM_Write_o, MEMWB_Bubble_o, MemTimeout_o, state_o, stall_cnt_o
  );

  modport slave (
    output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i, MemReq_i, MemAck_i,
    input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o, IDEX_Bubble_o,
           EXMEM_Write_o, MEMWB_Bubble_o, MemTimeout_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch squash slots, data-memory waits.
// Optional macro STALL_CNT_EN enables the saturating stall-cycle counter on stall_cnt_o.
module hazard_ctrl #(
  parameter int FLUSH_SLOTS = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_FLUSH = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  localparam logic [1:0]      SLOT_INIT = 2'(FLUSH_SLOTS - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit              TO_EN     = (MEM_TIMEOUT > 0);

  state_t          state_q, state_d, eval_state, ret_state;
  logic [1:0]      slot_q, slot_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            to_q, to_d;
  logic            miss, lu;
  logic            pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;

  assign miss = hz.MemReq_i & ~hz.MemAck_i;
  assign lu   = hz.IDEX_MemRead_i & (hz.IDEX_Rt_i != 5'd0) &
                ((hz.IDEX_Rt_i == hz.IFID_Rs_i) | (hz.IDEX_Rt_i == hz.IFID_Rt_i));
  assign ret_state = (slot_q != 2'd0) ? S_FLUSH : S_RUN;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RUN;
      slot_q  <= 2'd0;
      wait_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    slot_d       = slot_q;
    wait_d       = wait_q;
    to_d         = to_q;
    // An acked wait cycle behaves exactly like the state it returns to.
    eval_state   = (state_q == S_WAIT) ? ret_state : state_q;

    if ((state_q == S_WAIT) && !hz.MemAck_i) begin
      memwb_bubble = 1'b1;
      if (TO_EN && (wait_q == TO_LAST)) begin
        to_d    = 1'b1;
        state_d = ret_state;
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        wait_d      = wait_q + 1'b1;
      end
    end else if (miss) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = S_WAIT;
      wait_d       = '0;
    end else if (lu) begin
      // The slot is held, not consumed, while the load-use bubble is inserted.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = (eval_state == S_FLUSH);
      state_d     = eval_state;
    end else if (eval_state == S_FLUSH) begin
      ifid_flush = 1'b1;
      slot_d     = slot_q - 2'd1;
      state_d    = (slot_q == 2'd1) ? S_RUN : S_FLUSH;
    end else if (hz.Branch_i) begin
      ifid_flush = 1'b1;
      slot_d     = SLOT_INIT;
      state_d    = (FLUSH_SLOTS > 1) ? S_FLUSH : S_RUN;
    end else begin
      state_d = S_RUN;
    end

    if (!rst_i) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end
  end

  assign hz.PC_Write_o     = pc_write;
  assign hz.IFID_Write_o   = ifid_write;
  assign hz.IFID_Flush_o   = ifid_flush;
  assign hz.IDEX_Write_o   = idex_write;
  assign hz.IDEX_Bubble_o  = idex_bubble;
  assign hz.EXMEM_Write_o  = exmem_write;
  assign hz.MEMWB_Bubble_o = memwb_bubble;
  assign hz.MemTimeout_o   = to_q;
  assign hz.state_o        = state_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
`endif

endmodule
